// File: rtl/iq_alu_queue_pkg.sv
// Shared definitions for the ALU issue queue.
// Contents:
//   - queue geometry: IQ_DEPTH, TAG_W, N_WAKE, ENTRY_W, SLOT_W
//   - entry-word field positions (F_*)
//   - SEL_NONE, the "no slot" code used by select
//   - wake_match / operand_ready helper functions
package iq_pkg;

    localparam int IQ_DEPTH = 7;
    localparam int TAG_W    = 5;
    localparam int N_WAKE   = 4;
    localparam int ENTRY_W  = 21;
    localparam int SLOT_W   = 3;

    localparam int F_ISSUED  = 0;
    localparam int F_VALID   = 1;
    localparam int F_PRD_LO  = 2;
    localparam int F_RDY1    = 7;
    localparam int F_PRS1_LO = 8;
    localparam int F_DSTWR   = 13;
    localparam int F_RDY2    = 14;
    localparam int F_PRS2_LO = 15;
    localparam int F_RSVD    = 20;

    localparam logic [SLOT_W-1:0] SEL_NONE = 3'd7;

    // True when any enabled wakeup bus carries the given tag.
    function automatic logic wake_match(
        input logic [TAG_W-1:0]        tag,
        input logic [N_WAKE-1:0]       wake_en,
        input logic [N_WAKE*TAG_W-1:0] wake_tag
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_WAKE; i++) begin
            if (wake_en[i] && (wake_tag[i*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Ready state of a source operand as it is written at dispatch:
    // already ready, the zero register, or woken up on this very edge.
    function automatic logic operand_ready(
        input logic [TAG_W-1:0]        tag,
        input logic                    rdy,
        input logic [N_WAKE-1:0]       wake_en,
        input logic [N_WAKE*TAG_W-1:0] wake_tag
    );
        return rdy | (tag == '0) | wake_match(tag, wake_en, wake_tag);
    endfunction

endpackage

// File: rtl/iq_alu_queue_if.sv
// Dispatch / wakeup / select / slot-content bundle of the ALU issue queue.
//   master: the pipeline around the queue (drives dispatch, wakeup, select, flush)
//   slave : the queue itself (drives disp_ready, free_cnt, IQ_ALU_dout0..6)
interface iq_alu_queue_if;
    import iq_pkg::*;

    logic                      flush;
    logic                      disp_en0;
    logic                      disp_en1;
    logic [ENTRY_W-1:0]        disp_entry0;
    logic [ENTRY_W-1:0]        disp_entry1;
    logic                      disp_ready;
    logic [2:0]                free_cnt;
    logic [N_WAKE-1:0]         wake_en;
    logic [N_WAKE*TAG_W-1:0]   wake_tag;
    logic                      sel_en0;
    logic                      sel_en1;
    logic [SLOT_W-1:0]         sel_num0;
    logic [SLOT_W-1:0]         sel_num1;
    logic [ENTRY_W-1:0]        IQ_ALU_dout0;
    logic [ENTRY_W-1:0]        IQ_ALU_dout1;
    logic [ENTRY_W-1:0]        IQ_ALU_dout2;
    logic [ENTRY_W-1:0]        IQ_ALU_dout3;
    logic [ENTRY_W-1:0]        IQ_ALU_dout4;
    logic [ENTRY_W-1:0]        IQ_ALU_dout5;
    logic [ENTRY_W-1:0]        IQ_ALU_dout6;

    modport master (
        output flush, disp_en0, disp_en1, disp_entry0, disp_entry1,
               wake_en, wake_tag, sel_en0, sel_en1, sel_num0, sel_num1,
        input  disp_ready, free_cnt,
               IQ_ALU_dout0, IQ_ALU_dout1, IQ_ALU_dout2, IQ_ALU_dout3,
               IQ_ALU_dout4, IQ_ALU_dout5, IQ_ALU_dout6
    );

    modport slave (
        input  flush, disp_en0, disp_en1, disp_entry0, disp_entry1,
               wake_en, wake_tag, sel_en0, sel_en1, sel_num0, sel_num1,
        output disp_ready, free_cnt,
               IQ_ALU_dout0, IQ_ALU_dout1, IQ_ALU_dout2, IQ_ALU_dout3,
               IQ_ALU_dout4, IQ_ALU_dout5, IQ_ALU_dout6
    );
endinterface

// File: rtl/iq_alu_queue_entry.sv
// One issue-queue slot holding a 21-bit entry word.
// Ports:
//   clk, rst      clock / asynchronous active-high reset
//   flush_i       drop the slot (valid/issued cleared)
//   wr_en_i       dispatch write into this (free) slot, data wr_data_i
//   wake_en_i     per-bus wakeup valid, wake_tag_i the packed bus tags
//   grant_i       select grant for this slot
//   word_o        registered slot contents
module iq_entry
    import iq_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      wr_en_i,
    input  logic [ENTRY_W-1:0]        wr_data_i,
    input  logic [N_WAKE-1:0]         wake_en_i,
    input  logic [N_WAKE*TAG_W-1:0]   wake_tag_i,
    input  logic                      grant_i,
    output logic [ENTRY_W-1:0]        word_o
);

    logic [ENTRY_W-1:0] word_q;
    logic [ENTRY_W-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (flush_i) begin
            word_d[F_VALID]  = 1'b0;
            word_d[F_ISSUED] = 1'b0;
        end else if (word_q[F_VALID] && word_q[F_ISSUED]) begin
            // issued last edge: release the slot now
            word_d[F_VALID]  = 1'b0;
            word_d[F_ISSUED] = 1'b0;
        end else if (word_q[F_VALID]) begin
            // waiting: snoop wakeups (set-only) and accept a grant
            if (wake_match(word_q[F_PRS1_LO +: TAG_W], wake_en_i, wake_tag_i)) begin
                word_d[F_RDY1] = 1'b1;
            end
            if (wake_match(word_q[F_PRS2_LO +: TAG_W], wake_en_i, wake_tag_i)) begin
                word_d[F_RDY2] = 1'b1;
            end
            if (grant_i) begin
                word_d[F_ISSUED] = 1'b1;
            end
        end else if (wr_en_i) begin
            word_d           = wr_data_i;
            word_d[F_ISSUED] = 1'b0;
            word_d[F_VALID]  = 1'b1;
            word_d[F_RSVD]   = 1'b0;
            word_d[F_RDY1]   = operand_ready(wr_data_i[F_PRS1_LO +: TAG_W],
                                             wr_data_i[F_RDY1], wake_en_i, wake_tag_i);
            word_d[F_RDY2]   = operand_ready(wr_data_i[F_PRS2_LO +: TAG_W],
                                             wr_data_i[F_RDY2], wake_en_i, wake_tag_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/iq_alu_queue.sv
// 7-slot ALU issue queue: two dispatch lanes, four wakeup buses, two select grants.
// Ports:
//   clk, rst   clock / asynchronous active-high reset
//   bus        iq_alu_queue_if.slave: dispatch, wakeup, select, flush in;
//              disp_ready, free_cnt and the seven slot words out
// The top holds the two-lane free-slot finder and the free-slot popcount;
// each slot's state lives in an iq_entry.
module iq_alu_queue
    import iq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    iq_alu_queue_if.slave  bus
);

    logic [ENTRY_W-1:0] slot_word [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] valid_vec;
    logic [IQ_DEPTH-1:0] wr_en;
    logic [ENTRY_W-1:0]  wr_data [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] grant;
    logic [SLOT_W-1:0]   slot_a;
    logic [SLOT_W-1:0]   slot_b;
    logic                have_a;
    logic [2:0]          free_cnt_w;
    logic                disp_ready_w;
    logic                accept;

    // Lowest two free slots and the free count, all from registered valid bits.
    always_comb begin
        slot_a     = SEL_NONE;
        slot_b     = SEL_NONE;
        have_a     = 1'b0;
        free_cnt_w = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (!valid_vec[i]) begin
                free_cnt_w = free_cnt_w + 3'd1;
                if (!have_a) begin
                    slot_a = SLOT_W'(i);
                    have_a = 1'b1;
                end else if (slot_b == SEL_NONE) begin
                    slot_b = SLOT_W'(i);
                end
            end
        end
    end

    assign disp_ready_w = (free_cnt_w >= 3'd2);
    assign accept       = disp_ready_w && !bus.flush;

    // Lane 1 moves down to the lowest free slot when lane 0 is idle.
    // Since accept needs two free slots, slot_a and slot_b both exist here.
    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            wr_en[i]   = 1'b0;
            wr_data[i] = '0;
            if (accept) begin
                if (bus.disp_en0 && (slot_a == SLOT_W'(i))) begin
                    wr_en[i]   = 1'b1;
                    wr_data[i] = bus.disp_entry0;
                end
                if (bus.disp_en1 && ((bus.disp_en0 ? slot_b : slot_a) == SLOT_W'(i))) begin
                    wr_en[i]   = 1'b1;
                    wr_data[i] = bus.disp_entry1;
                end
            end
            // a duplicate grant pair collapses into one grant by the OR
            grant[i] = (bus.sel_en0 && (bus.sel_num0 == SLOT_W'(i))) ||
                       (bus.sel_en1 && (bus.sel_num1 == SLOT_W'(i)));
        end
    end

    generate
        for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : g_slot
            iq_entry u_entry (
                .clk        (clk),
                .rst        (rst),
                .flush_i    (bus.flush),
                .wr_en_i    (wr_en[gi]),
                .wr_data_i  (wr_data[gi]),
                .wake_en_i  (bus.wake_en),
                .wake_tag_i (bus.wake_tag),
                .grant_i    (grant[gi]),
                .word_o     (slot_word[gi])
            );
            assign valid_vec[gi] = slot_word[gi][F_VALID];
        end
    endgenerate

    assign bus.free_cnt     = free_cnt_w;
    assign bus.disp_ready   = disp_ready_w;
    assign bus.IQ_ALU_dout0 = slot_word[0];
    assign bus.IQ_ALU_dout1 = slot_word[1];
    assign bus.IQ_ALU_dout2 = slot_word[2];
    assign bus.IQ_ALU_dout3 = slot_word[3];
    assign bus.IQ_ALU_dout4 = slot_word[4];
    assign bus.IQ_ALU_dout5 = slot_word[5];
    assign bus.IQ_ALU_dout6 = slot_word[6];

    // Select must never grant the same slot on both ports.
    a_dup_grant: assert property (@(posedge clk) disable iff (rst)
        !(bus.sel_en0 && bus.sel_en1 && (bus.sel_num0 == bus.sel_num1)))
        else $error("duplicate select grant to slot %0d", bus.sel_num0);

endmodule

// File: tb/tb_iq_alu_queue.sv
// Directed bench for iq_alu_queue: reset, dispatch, wakeup/bypass, select/free,
// full queue, flush and asynchronous reset in the middle of operation.
module tb_iq_alu_queue;
    import iq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    localparam logic [20:0] B_ISSUED = 21'h000001;
    localparam logic [20:0] B_VALID  = 21'h000002;
    localparam logic [20:0] B_RDY1   = 21'h000080;
    localparam logic [20:0] B_RDY2   = 21'h004000;

    iq_alu_queue_if bus ();

    iq_alu_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] mk(input logic [4:0] prd, input logic [4:0] prs1,
                                       input logic rdy1, input logic dst,
                                       input logic [4:0] prs2, input logic rdy2);
        return {1'b0, prs2, rdy2, dst, prs1, rdy1, prd, 2'b00};
    endfunction

    function automatic logic [20:0] dout(input int i);
        case (i)
            0: return bus.IQ_ALU_dout0;
            1: return bus.IQ_ALU_dout1;
            2: return bus.IQ_ALU_dout2;
            3: return bus.IQ_ALU_dout3;
            4: return bus.IQ_ALU_dout4;
            5: return bus.IQ_ALU_dout5;
            default: return bus.IQ_ALU_dout6;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.flush       = 1'b0;
        bus.disp_en0    = 1'b0;
        bus.disp_en1    = 1'b0;
        bus.disp_entry0 = '0;
        bus.disp_entry1 = '0;
        bus.wake_en     = '0;
        bus.wake_tag    = '0;
        bus.sel_en0     = 1'b0;
        bus.sel_en1     = 1'b0;
        bus.sel_num0    = SEL_NONE;
        bus.sel_num1    = SEL_NONE;
    endtask

    // advance one edge, sample 1 time unit later, then return inputs to idle
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic dispatch(input logic en0, input logic [20:0] e0,
                            input logic en1, input logic [20:0] e1);
        bus.disp_en0    = en0;
        bus.disp_entry0 = e0;
        bus.disp_en1    = en1;
        bus.disp_entry1 = e1;
    endtask

    logic [20:0] e_a, e_b, e_c, e13, e14, e15, e16, e17, e18, w4;

    initial begin
        idle();
        rst = 1'b1;
        #3;
        chk("reset_dout0", 32'(dout(0)), 32'h0);
        chk("reset_dout6", 32'(dout(6)), 32'h0);
        chk("reset_free_cnt", 32'(bus.free_cnt), 32'd7);
        chk("reset_disp_ready", 32'(bus.disp_ready), 32'd1);
        #9;
        rst = 1'b0;
        tick();

        // T2: dual dispatch, prs1=3 not ready, prs2=0 (zero reg -> ready)
        e_a = mk(5'd10, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0);
        e_b = mk(5'd11, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0);
        dispatch(1'b1, e_a, 1'b1, e_b);
        tick();
        chk("t2_slot0", 32'(dout(0)), 32'(e_a | B_VALID | B_RDY2));
        chk("t2_slot1", 32'(dout(1)), 32'(e_b | B_VALID | B_RDY2));
        chk("t2_slot2_empty", 32'(dout(2)), 32'h0);
        chk("t2_free_cnt", 32'(bus.free_cnt), 32'd5);

        // T3a: LS bus (index 2) wakes tag 3
        bus.wake_en  = 4'b0100;
        bus.wake_tag = 20'd3 << 10;
        tick();
        chk("t3_wake_slot0", 32'(dout(0)), 32'(e_a | B_VALID | B_RDY2 | B_RDY1));
        chk("t3_wake_slot1", 32'(dout(1)), 32'(e_b | B_VALID | B_RDY2 | B_RDY1));

        // T3b: lane 1 only, bypassed wakeup of prs1=3 on bus 0; prs2=9 stays pending
        e_c = mk(5'd12, 5'd3, 1'b0, 1'b0, 5'd9, 1'b0);
        dispatch(1'b0, '0, 1'b1, e_c);
        bus.wake_en  = 4'b0001;
        bus.wake_tag = 20'd3;
        tick();
        chk("t3_bypass_slot2", 32'(dout(2)), 32'(e_c | B_VALID | B_RDY1));
        chk("t3_free_cnt", 32'(bus.free_cnt), 32'd4);

        // T3c: tag 9 on buses 1 and 3 together
        bus.wake_en  = 4'b1010;
        bus.wake_tag = (20'd9 << 5) | (20'd9 << 15);
        tick();
        chk("t3_multi_wake_slot2", 32'(dout(2)), 32'(e_c | B_VALID | B_RDY1 | B_RDY2));

        // T4: grant slot 1; grant to empty slot 5 must be ignored
        bus.sel_en0  = 1'b1;
        bus.sel_num0 = 3'd1;
        bus.sel_en1  = 1'b1;
        bus.sel_num1 = 3'd5;
        tick();
        chk("t4_slot1_issued", 32'(dout(1)), 32'(e_b | B_VALID | B_RDY2 | B_RDY1 | B_ISSUED));
        chk("t4_slot5_ignored", 32'(dout(5)), 32'h0);
        chk("t4_free_cnt_issued", 32'(bus.free_cnt), 32'd4);
        tick();
        chk("t4_slot1_freed", 32'(dout(1) & 21'h3), 32'h0);
        chk("t4_free_cnt_freed", 32'(bus.free_cnt), 32'd5);

        // T5: valid slots are 0 and 2; fill 1,3 then 4,5
        e13 = mk(5'd13, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        e14 = mk(5'd14, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        e15 = mk(5'd15, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        e16 = mk(5'd16, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        e17 = mk(5'd17, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        e18 = mk(5'd18, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        dispatch(1'b1, e13, 1'b1, e14);
        tick();
        chk("t5_slot1_reuse", 32'(dout(1)), 32'(e13 | B_VALID | B_RDY1 | B_RDY2));
        chk("t5_slot3", 32'(dout(3)), 32'(e14 | B_VALID | B_RDY1 | B_RDY2));
        chk("t5_free_cnt3", 32'(bus.free_cnt), 32'd3);
        dispatch(1'b1, e15, 1'b1, e16);
        tick();
        w4 = e15 | B_VALID | B_RDY1 | B_RDY2;
        chk("t5_slot4", 32'(dout(4)), 32'(w4));
        chk("t5_slot5", 32'(dout(5)), 32'(e16 | B_VALID | B_RDY1 | B_RDY2));
        chk("t5_full_free_cnt", 32'(bus.free_cnt), 32'd1);
        chk("t5_full_disp_ready", 32'(bus.disp_ready), 32'd0);
        dispatch(1'b1, e17, 1'b1, e18);
        tick();
        chk("t5_drop_slot6", 32'(dout(6)), 32'h0);
        chk("t5_drop_slot4", 32'(dout(4)), 32'(w4));
        chk("t5_drop_free_cnt", 32'(bus.free_cnt), 32'd1);

        // T6: flush together with a grant (a dispatch would be dropped anyway)
        bus.flush    = 1'b1;
        bus.sel_en0  = 1'b1;
        bus.sel_num0 = 3'd0;
        dispatch(1'b1, e17, 1'b1, e18);
        tick();
        for (int i = 0; i < IQ_DEPTH; i++) begin
            chk($sformatf("t6_flush_slot%0d", i), 32'(dout(i) & 21'h3), 32'h0);
        end
        chk("t6_free_cnt", 32'(bus.free_cnt), 32'd7);
        chk("t6_disp_ready", 32'(bus.disp_ready), 32'd1);

        // dispatch after flush into slots 0,1; flush must not have blocked later dispatch
        dispatch(1'b1, e17, 1'b1, e18);
        tick();
        chk("t1_pre_slot0", 32'(dout(0)), 32'(e17 | B_VALID | B_RDY1 | B_RDY2));
        chk("t1_pre_free_cnt", 32'(bus.free_cnt), 32'd5);

        // T1: asynchronous reset mid-cycle, no clock edge in between
        rst = 1'b1;
        #2;
        chk("t1_rst_dout0", 32'(dout(0)), 32'h0);
        chk("t1_rst_dout1", 32'(dout(1)), 32'h0);
        chk("t1_rst_free_cnt", 32'(bus.free_cnt), 32'd7);
        chk("t1_rst_disp_ready", 32'(bus.disp_ready), 32'd1);
        rst = 1'b0;
        dispatch(1'b1, e13, 1'b0, '0);
        tick();
        chk("t1_post_slot0", 32'(dout(0)), 32'(e13 | B_VALID | B_RDY1 | B_RDY2));
        chk("t1_post_free_cnt", 32'(bus.free_cnt), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // guard against a stuck run
    initial begin
        #20000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
